// File: rtl/structure_expand_channel_pipelined_subs_if.sv
// Valid/ready channel bundle for the structure-expand transmit path.
// The input side carries biased result words; the output side carries raw
// channel words toward a downstream structure-reduce stage.
interface structure_expand_channel_pipelined_subs_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    // Driver of the input channel and consumer of the output channel.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The expand block itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/structure_expand_channel_pipelined_subs.sv
// Structure-expand channel: strips a fixed bias from each accepted word and
// buffers the result in a small FIFO that drains onto the output channel.
// Optional build macro STRUCTURE_EXPAND_OVERFLOW_FLAG_EN: input is never
// back-pressured; words arriving at full are dropped and a sticky overflow
// flag is raised until reset.
module structure_expand_channel_pipelined_subs #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int BIAS  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    structure_expand_channel_pipelined_subs_if.slave bus,
`ifdef STRUCTURE_EXPAND_OVERFLOW_FLAG_EN
    output logic                       overflow,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Occupancy alone decides readiness; a same-cycle pop never opens a full FIFO.
    always_comb begin
        full          = (count_q == CW'(DEPTH));
        empty         = (count_q == '0);
        push          = bus.in_valid && !full;
        pop           = !empty && bus.out_ready;
`ifdef STRUCTURE_EXPAND_OVERFLOW_FLAG_EN
        bus.in_ready  = 1'b1;
`else
        bus.in_ready  = !full;
`endif
        bus.out_valid = !empty;
        bus.out_data  = empty ? '0 : mem[rd_ptr];
        count         = count_q;
    end

    // Storage write of the unbiased word; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= bus.in_data - WIDTH'(BIAS);
        end
    end

    // Pointer and occupancy bookkeeping; reset overrides any push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

`ifdef STRUCTURE_EXPAND_OVERFLOW_FLAG_EN
    // Sticky flag for any word that arrived while the FIFO was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (bus.in_valid && full) begin
            overflow <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_structure_expand_channel_pipelined_subs.sv
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a queue-based reference of the channel behaviour.
module tb_structure_expand_channel_pipelined_subs;
    localparam int W = 16;
    localparam int D = 4;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] count;
`ifdef STRUCTURE_EXPAND_OVERFLOW_FLAG_EN
    logic       overflow;
    bit         ov_exp = 1'b0;
`endif

    structure_expand_channel_pipelined_subs_if #(.WIDTH(W)) bus ();

    structure_expand_channel_pipelined_subs #(.WIDTH(W), .DEPTH(D), .BIAS(B)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
`ifdef STRUCTURE_EXPAND_OVERFLOW_FLAG_EN
        .overflow (overflow),
`endif
        .count    (count)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [W-1:0] q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("out_data",  32'(bus.out_data),  32'(head));
`ifdef STRUCTURE_EXPAND_OVERFLOW_FLAG_EN
        chk("in_ready",  32'(bus.in_ready),  32'd1);
        chk("overflow",  32'(overflow),      32'(ov_exp));
`else
        chk("in_ready",  32'(bus.in_ready),  32'(q.size() != D));
`endif
        chk("count",     32'(count),         32'(q.size()));
    endtask

    // Called at a falling edge: check, drive, take one rising edge, update model.
    task automatic step(input bit r, input bit iv, input logic [W-1:0] d,
                        input bit ordy, output bit acc);
        bit popf;
        check_outputs();
        rst           = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        acc  = !r && iv && (q.size() < D);
        popf = !r && ordy && (q.size() != 0);
        @(posedge clk);
        if (r) begin
            q.delete();
`ifdef STRUCTURE_EXPAND_OVERFLOW_FLAG_EN
            ov_exp = 1'b0;
`endif
        end else begin
`ifdef STRUCTURE_EXPAND_OVERFLOW_FLAG_EN
            if (iv && q.size() == D) ov_exp = 1'b1;
`endif
            if (popf) void'(q.pop_front());
            if (acc)  q.push_back(d - W'(B));
        end
        @(negedge clk);
    endtask

    // Holds a word on the input until it is taken, with a bounded wait.
    task automatic push_hold(input logic [W-1:0] d, input bit ordy);
        bit acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b0, 1'b1, d, ordy, acc);
        chk("push_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        bit acc;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // basic stream
        step(1'b0, 1'b1, 16'd12, 1'b1, acc);
        chk("first_word", 32'(bus.out_data), 32'd10);
        step(1'b0, 1'b1, 16'd15, 1'b1, acc);
        chk("second_word", 32'(bus.out_data), 32'd13);
        step(1'b0, 1'b0, 16'hAAAA, 1'b1, acc);
        step(1'b0, 1'b0, 16'h5555, 1'b1, acc);

        // wrap arithmetic
        step(1'b0, 1'b1, 16'd1, 1'b1, acc);
        chk("wrap_ffff", 32'(bus.out_data), 32'hFFFF);
        step(1'b0, 1'b1, 16'd0, 1'b1, acc);
        chk("wrap_fffe", 32'(bus.out_data), 32'hFFFE);
        step(1'b0, 1'b0, 16'd0, 1'b1, acc);

        // fill, backpressure, drain
        for (int i = 10; i < 14; i++) step(1'b0, 1'b1, 16'(i), 1'b0, acc);
        chk("full_count", 32'(count), 32'd4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'd99, 1'b0, acc);
        push_hold(16'd99, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'd0, 1'b1, acc);

        // simultaneous push/pop at count 2
        step(1'b0, 1'b1, 16'd30, 1'b0, acc);
        step(1'b0, 1'b1, 16'd31, 1'b0, acc);
        step(1'b0, 1'b1, 16'd32, 1'b1, acc);
        chk("pushpop_count", 32'(count), 32'd2);
        chk("pushpop_head", 32'(bus.out_data), 32'd29);

        // reset mid-burst at count 3
        step(1'b0, 1'b1, 16'd33, 1'b0, acc);
        step(1'b1, 1'b1, 16'd77, 1'b0, acc);
        chk("midreset_count", 32'(count), 32'd0);
        chk("midreset_valid", 32'(bus.out_valid), 32'd0);

`ifdef STRUCTURE_EXPAND_OVERFLOW_FLAG_EN
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'(40 + i), 1'b0, acc);
        step(1'b0, 1'b1, 16'd50, 1'b0, acc);
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'd0, 1'b1, acc);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        step(1'b1, 1'b0, 16'd0, 1'b0, acc);
        chk("ovf_cleared", 32'(overflow), 32'd0);
`endif

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 7,
                 W'($urandom),
                 $urandom_range(0, 9) < ((i / 200) % 2 == 0 ? 6 : 3),
                 acc);
        end
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
